// File: rtl/core_seq_ctrl.sv
// core_seq_ctrl: multi-cycle fetch/decode/exec/mem/wb sequencer for the NPC core.
// Ports: imem/dmem valid-ready handshakes, dec_* decoder flags, rf/pc strobes,
// sticky halted/trap with trap_cause, 64-bit instret, state_o debug view.
module core_seq_ctrl #(
  parameter int TIMEOUT = 256,
  parameter int CNT_W   = 9
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  output logic        inst_wen,
  input  logic        dec_reg_wen,
  input  logic        dec_mem_wen,
  input  logic        dec_is_load,
  input  logic        dec_is_ebreak,
  input  logic        dec_inst_not_ipl,
  output logic        dmem_req_valid,
  output logic        dmem_req_we,
  input  logic        dmem_req_ready,
  input  logic        dmem_rsp_valid,
  output logic        rf_wen,
  output logic        pc_wen,
  output logic        halted,
  output logic        trap,
  output logic [1:0]  trap_cause,
  output logic [63:0] instret,
  output logic [3:0]  state_o
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_WAIT_I   = 4'd1,
    S_DECODE   = 4'd2,
    S_EXEC     = 4'd3,
    S_MEM_REQ  = 4'd4,
    S_MEM_WAIT = 4'd5,
    S_WB       = 4'd6,
    S_HALT     = 4'd7,
    S_TRAP     = 4'd8
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W:0]   cnt_nx;
  logic             tmo;
  logic             reg_wen_q, st_q, ld_q;
  logic [1:0]       cause_q, cause_d;
  logic [63:0]      instret_q;
  logic             cnt_clr;

  // Trap decision is made in the cycle whose wait would bring
  // the count up to TIMEOUT; a response in that cycle still wins.
  assign cnt_nx = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};
  assign tmo    = (TIMEOUT != 0) &&
                  (cnt_nx == (CNT_W+1)'(TIMEOUT));

  always_comb begin
    state_d = state_q;
    cause_d = cause_q;
    unique case (state_q)
      S_FETCH:
        if (imem_req_ready) state_d = S_WAIT_I;
      S_WAIT_I:
        if (imem_rsp_valid) state_d = S_DECODE;
        else if (tmo) begin
          state_d = S_TRAP;
          cause_d = 2'd1;
        end
      S_DECODE:
        if (dec_is_ebreak) state_d = S_HALT;
        else if (dec_inst_not_ipl) begin
          state_d = S_TRAP;
          cause_d = 2'd2;
        end
        else state_d = S_EXEC;
      S_EXEC:
        state_d = (ld_q | st_q) ? S_MEM_REQ : S_WB;
      S_MEM_REQ:
        if (dmem_req_ready)
          state_d = st_q ? S_WB : S_MEM_WAIT;
      S_MEM_WAIT:
        if (dmem_rsp_valid) state_d = S_WB;
        else if (tmo) begin
          state_d = S_TRAP;
          cause_d = 2'd3;
        end
      S_WB:
        state_d = S_FETCH;
      S_HALT:
        state_d = S_HALT;
      S_TRAP:
        state_d = S_TRAP;
      default:
        state_d = S_FETCH;
    endcase
  end

  assign cnt_clr =
    ((state_d == S_WAIT_I) && (state_q != S_WAIT_I)) ||
    ((state_d == S_MEM_WAIT) && (state_q != S_MEM_WAIT));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_FETCH;
      cause_q   <= 2'd0;
      cnt_q     <= '0;
      reg_wen_q <= 1'b0;
      st_q      <= 1'b0;
      ld_q      <= 1'b0;
      instret_q <= 64'd0;
    end else begin
      state_q <= state_d;
      cause_q <= cause_d;
      if (cnt_clr)
        cnt_q <= '0;
      else if (state_q == S_WAIT_I ||
               state_q == S_MEM_WAIT)
        cnt_q <= cnt_q + 1'b1;
      if (state_q == S_DECODE) begin
        reg_wen_q <= dec_reg_wen;
        st_q      <= dec_mem_wen;
        ld_q      <= dec_is_load;
      end
      if (state_q == S_WB)
        instret_q <= instret_q + 64'd1;
    end
  end

  // Outputs are gated by rst so requests drop the moment reset
  // is asserted, before the async state update is observable.
  assign imem_req_valid = ~rst & (state_q == S_FETCH);
  assign inst_wen       = ~rst & (state_q == S_WAIT_I)
                               & imem_rsp_valid;
  assign dmem_req_valid = ~rst & (state_q == S_MEM_REQ);
  assign dmem_req_we    = ~rst & (state_q == S_MEM_REQ) & st_q;
  assign rf_wen         = ~rst & (state_q == S_WB) & reg_wen_q;
  assign pc_wen         = ~rst & (state_q == S_WB);
  assign halted         = ~rst & (state_q == S_HALT);
  assign trap           = ~rst & (state_q == S_TRAP);
  assign trap_cause     = cause_q;
  assign instret        = instret_q;
  assign state_o        = state_q;

endmodule
